cargador_operandos: RTL and testbench
=====================================

// Module: cargador_operandos
// PURPOSE
//  Clocked, parametrised operand loader for the ALU datapath: captures A, B and OP
//  from the shared switch bus `entrada` on debounced button presses.
//  Each button passes a 2-FF synchroniser, a debounce counter and a rising-edge
//  detector, so every press loads exactly once.
//  Provides a `listo` level and a `nuevo` strobe so the ALU/display stage knows
//  when a complete, fresh operand set is present.
// PARAMETERS
//  DAT_W    8  width of entrada, a, b
//  OP_W     6  width of op; op <= entrada[OP_W-1:0]; OP_W <= DAT_W
//  DEB_CYC  4  consecutive stable cycles required to accept a button level change; >= 1
// PORTS
//  clk        in   1      single system clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  entrada    in   DAT_W  switch bus; must be quasi-static, sampled directly on load
//  boton_a    in   1      raw (bouncy, async) load-A button
//  boton_b    in   1      raw load-B button
//  boton_op   in   1      raw load-OP button
//  a          out  DAT_W  operand A register
//  b          out  DAT_W  operand B register
//  op         out  OP_W   opcode register
//  listo      out  1      high once A, B and OP have each been loaded since reset
//  nuevo      out  1      one-cycle pulse, cycle after any load that leaves listo=1
//  sel        out  2      next target in sequential mode (0=A,1=B,2=OP); 0 otherwise
// BEHAVIOUR
//  Reset (async on rst_n=0): a=0, b=0, op=0, listo=0, nuevo=0, sel=0; sync FFs,
//   debounced levels, counters and loaded flags all 0. Release is applied on the next clk.
//  Sync: s1<=raw, s2<=s1 per button.
//  Debounce, per button: if s2==deb then cnt<=0; else if cnt==DEB_CYC-1 then deb<=s2
//   and cnt<=0; else cnt<=cnt+1. Counter width $clog2(DEB_CYC+1).
//  Glitch: s2 differing for fewer than DEB_CYC cycles -> cnt clears, no level change, no load.
//  Edge: pulse = deb & ~deb_q (deb_q registered deb). Falling edges are ignored.
//  Load: the register updates on the clk edge where pulse=1.
//   Latency: raw held high from the first sampling edge E -> output updated at edge E+DEB_CYC+2.
//  Priority: pulses in the same cycle -> A > B > OP; only one loads, the others are dropped,
//   not queued.
//  A button held down loads once; a reload requires release (debounced low), then a new press.
//  Flags fa, fb, fop are set on their load and stay set until reset; listo = fa&fb&fop (registered).
//  nuevo: asserted the cycle after a load whose resulting flags are all 1, including reloads.
//  Reset mid-debounce or mid-press aborts everything; no load occurs after release
//   until a fresh debounced edge.
// CONFIGURATION
//  Macro CARGADOR_SEQ_EN:
//   defined   - single-button sequential mode. boton_a edges step FSM S_A->S_B->S_OP->S_A,
//               loading a/b/op respectively. sel = current state (reset S_A).
//               boton_b (debounced edge) returns FSM to S_A without loading; boton_op is ignored.
//               An edge on boton_a and boton_b in the same cycle loads per the current state,
//               then goes to S_A.
//   undefined - three independent buttons as above; sel tied to 0; no FSM logic.
// TESTING (DEB_CYC=4, DAT_W=8, OP_W=6)
//  1 Reset: rst_n=0 asynchronously mid-cycle -> a=b=op=0, listo=nuevo=0 immediately.
//  2 entrada=8'h3C, boton_a high from edge E -> a=8'h3C at edge E+6, not earlier;
//    holding for 50 cycles gives no reload.
//  3 boton_b pulse of 3 cycles (bounce) -> b unchanged; pulse of 4+ cycles -> b=entrada.
//  4 Load A=8'h05, B=8'h03, OP from entrada=8'hE2 (op=6'h22) -> listo=1 after op load;
//    nuevo pulses once, one cycle later; reload B=8'h07 -> nuevo pulses again.
//  5 boton_a and boton_op rising together, entrada=8'h11 -> a=8'h11, op unchanged, no later op load.
//  6 CARGADOR_SEQ_EN: 3 boton_a presses with entrada 8'h01, 8'h02, 8'h03 -> a=01, b=02,
//    op=03, sel 0->1->2->0; boton_b press after the first press -> sel=0.

Source files
------------

// File: rtl/cargador_operandos_if.sv
// Bus interface for cargador_operandos: switch bus, raw buttons and operand outputs.
// The loader drives the operands through the slave modport; the stimulus side uses master.
interface cargador_operandos_if #(
    parameter int unsigned DAT_W = 8,
    parameter int unsigned OP_W  = 6
);
    logic [DAT_W-1:0] entrada;
    logic             boton_a;
    logic             boton_b;
    logic             boton_op;
    logic [DAT_W-1:0] a;
    logic [DAT_W-1:0] b;
    logic [OP_W-1:0]  op;
    logic             listo;
    logic             nuevo;
    logic [1:0]       sel;

    modport master (
        output entrada, boton_a, boton_b, boton_op,
        input  a, b, op, listo, nuevo, sel
    );

    modport slave (
        input  entrada, boton_a, boton_b, boton_op,
        output a, b, op, listo, nuevo, sel
    );
endinterface

// File: rtl/cargador_operandos.sv
// Operand loader: captures A, B and OP from the switch bus on debounced button presses.
// Each button goes through a 2-FF synchroniser, a debounce counter and a rising-edge detector.
// Optional macro CARGADOR_SEQ_EN selects single-button sequential mode (boton_a steps A->B->OP,
// boton_b returns to A, boton_op ignored); undefined gives three independent buttons.
module cargador_operandos #(
    parameter int unsigned DAT_W   = 8,
    parameter int unsigned OP_W    = 6,
    parameter int unsigned DEB_CYC = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    cargador_operandos_if.slave bus
);
    localparam int unsigned    CNT_W   = $clog2(DEB_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Button index: 0 = A, 1 = B, 2 = OP
    logic [2:0]       w_raw;
    logic [2:0]       r_s1, r_s2, r_deb, r_deb_q;
    logic [CNT_W-1:0] r_cnt [3];
    logic [2:0]       w_pulse;

    logic             w_ld_a, w_ld_b, w_ld_op;
    logic             w_fa_d, w_fb_d, w_fop_d, w_all_d, w_any_ld;
    logic [DAT_W-1:0] r_a, r_b;
    logic [OP_W-1:0]  r_op;
    logic             r_fa, r_fb, r_fop, r_listo, r_nuevo;

    assign w_raw   = {bus.boton_op, bus.boton_b, bus.boton_a};
    assign w_pulse = r_deb & ~r_deb_q;

    // Two-stage synchroniser for the asynchronous button inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= w_raw;
            r_s2 <= r_s1;
        end
    end

    // Debounce: accept a level only after DEB_CYC consecutive differing cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_deb   <= '0;
            r_deb_q <= '0;
            for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
        end else begin
            r_deb_q <= r_deb;
            for (int i = 0; i < 3; i++) begin
                if (r_s2[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_deb[i] <= r_s2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_ONE;
                end
            end
        end
    end

`ifdef CARGADOR_SEQ_EN
    typedef enum logic [1:0] {StA = 2'd0, StB = 2'd1, StOp = 2'd2} state_e;
    state_e r_state, w_state_d;

    // Sequencer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= StA;
        else        r_state <= w_state_d;
    end

    // boton_a loads the current target and advances; boton_b returns to A after any load
    always_comb begin
        w_state_d = r_state;
        w_ld_a    = 1'b0;
        w_ld_b    = 1'b0;
        w_ld_op   = 1'b0;
        if (w_pulse[0]) begin
            case (r_state)
                StA:     begin w_ld_a  = 1'b1; w_state_d = StB;  end
                StB:     begin w_ld_b  = 1'b1; w_state_d = StOp; end
                StOp:    begin w_ld_op = 1'b1; w_state_d = StA;  end
                default: w_state_d = StA;
            endcase
        end
        if (w_pulse[1]) w_state_d = StA;
    end

    assign bus.sel = r_state;
`else
    // Simultaneous edges resolve A > B > OP; losers are dropped
    always_comb begin
        w_ld_a  = w_pulse[0];
        w_ld_b  = w_pulse[1] & ~w_pulse[0];
        w_ld_op = w_pulse[2] & ~w_pulse[1] & ~w_pulse[0];
    end

    assign bus.sel = 2'b00;
`endif

    assign w_fa_d   = r_fa  | w_ld_a;
    assign w_fb_d   = r_fb  | w_ld_b;
    assign w_fop_d  = r_fop | w_ld_op;
    assign w_all_d  = w_fa_d & w_fb_d & w_fop_d;
    assign w_any_ld = w_ld_a | w_ld_b | w_ld_op;

    // Operand registers, loaded flags and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_fa    <= 1'b0;
            r_fb    <= 1'b0;
            r_fop   <= 1'b0;
            r_listo <= 1'b0;
            r_nuevo <= 1'b0;
        end else begin
            if (w_ld_a)  r_a  <= bus.entrada;
            if (w_ld_b)  r_b  <= bus.entrada;
            if (w_ld_op) r_op <= bus.entrada[OP_W-1:0];
            r_fa    <= w_fa_d;
            r_fb    <= w_fb_d;
            r_fop   <= w_fop_d;
            r_listo <= w_all_d;
            r_nuevo <= w_any_ld & w_all_d;
        end
    end

    assign bus.a     = r_a;
    assign bus.b     = r_b;
    assign bus.op    = r_op;
    assign bus.listo = r_listo;
    assign bus.nuevo = r_nuevo;
endmodule

// File: tb/tb_cargador_operandos.sv
// Self-checking bench for cargador_operandos (DEB_CYC=4, DAT_W=8, OP_W=6).
// Expected operands come from a press-level model: each clean press loads the winning register.
module tb_cargador_operandos;
    localparam int unsigned DAT_W   = 8;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned DEB_CYC = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    cargador_operandos_if #(.DAT_W(DAT_W), .OP_W(OP_W)) bus ();

    cargador_operandos #(.DAT_W(DAT_W), .OP_W(OP_W), .DEB_CYC(DEB_CYC)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Press-level reference model
    logic [7:0] m_a, m_b;
    logic [5:0] m_op;
    bit         m_fa, m_fb, m_fop;

    function automatic void model_clear();
        m_a = '0; m_b = '0; m_op = '0;
        m_fa = 0; m_fb = 0; m_fop = 0;
    endfunction

    // Apply one press of the buttons in mask; returns the number of nuevo pulses expected
    function automatic int model_load(input logic [2:0] mask, input logic [7:0] val);
        if (mask[0])      begin m_a  = val;      m_fa  = 1; end
        else if (mask[1]) begin m_b  = val;      m_fb  = 1; end
        else if (mask[2]) begin m_op = val[5:0]; m_fop = 1; end
        return (mask != 0 && m_fa && m_fb && m_fop) ? 1 : 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a clean press: buttons in mask high for hold cycles, then low for rel cycles
    task automatic press(input logic [2:0] mask, input logic [7:0] val, input int hold,
                         input int rel, output int nuevo_cnt);
        nuevo_cnt    = 0;
        bus.entrada  = val;
        bus.boton_a  = mask[0];
        bus.boton_b  = mask[1];
        bus.boton_op = mask[2];
        for (int i = 0; i < hold; i++) begin tick(); nuevo_cnt += int'(bus.nuevo); end
        bus.boton_a  = 1'b0;
        bus.boton_b  = 1'b0;
        bus.boton_op = 1'b0;
        for (int i = 0; i < rel; i++) begin tick(); nuevo_cnt += int'(bus.nuevo); end
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        tick();
        tick();
        rst_n = 1'b1;
        model_clear();
        tick();
    endtask

    task automatic test_reset();
        bus.entrada  = '0;
        bus.boton_a  = 1'b0;
        bus.boton_b  = 1'b0;
        bus.boton_op = 1'b0;
        rst_n        = 1'b1;
        model_clear();
        #3 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.a, bus.b, bus.op, bus.listo, bus.nuevo, bus.sel} !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got a=%h b=%h op=%h listo=%b nuevo=%b sel=%0d want all 0",
                     bus.a, bus.b, bus.op, bus.listo, bus.nuevo, bus.sel);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        n_tests++;
        if ({bus.a, bus.b, bus.op, bus.listo, bus.nuevo} !== '0) begin
            n_fail++;
            $display("FAIL reset_release: got a=%h b=%h op=%h listo=%b want all 0",
                     bus.a, bus.b, bus.op, bus.listo);
        end
    endtask

    // Load lands at edge E+DEB_CYC+2 and a held button never reloads
    task automatic test_latency();
        int unsigned lat = DEB_CYC + 2;
        bus.entrada = 8'h3C;
        bus.boton_a = 1'b1;
        for (int unsigned i = 0; i <= lat; i++) begin
            tick();
            n_tests++;
            if (i < lat && bus.a !== m_a) begin
                n_fail++;
                $display("FAIL latency_early e%0d: got a=%h want %h", i, bus.a, m_a);
            end else if (i == lat && bus.a !== 8'h3C) begin
                n_fail++;
                $display("FAIL latency_load e%0d: got a=%h want 3c", i, bus.a);
            end
        end
        void'(model_load(3'b001, 8'h3C));
        bus.entrada = 8'hA5;
        for (int i = 0; i < 50; i++) tick();
        n_tests++;
        if (bus.a !== 8'h3C) begin
            n_fail++;
            $display("FAIL hold_no_reload: got a=%h want 3c", bus.a);
        end
        bus.boton_a = 1'b0;
        bus.entrada = 8'h3C;
        for (int i = 0; i < int'(DEB_CYC) + 6; i++) tick();
    endtask

    task automatic test_glitch();
        bus.entrada = 8'h5A;
        bus.boton_b = 1'b1;
        for (int i = 0; i < int'(DEB_CYC) - 1; i++) tick();
        bus.boton_b = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        n_tests++;
        if (bus.b !== m_b) begin
            n_fail++;
            $display("FAIL glitch_short: got b=%h want %h", bus.b, m_b);
        end
        bus.boton_b = 1'b1;
        for (int i = 0; i < int'(DEB_CYC); i++) tick();
        bus.boton_b = 1'b0;
        for (int i = 0; i < int'(DEB_CYC) + 8; i++) tick();
        void'(model_load(3'b010, 8'h5A));
        n_tests++;
        if (bus.b !== m_b) begin
            n_fail++;
            $display("FAIL glitch_min_press: got b=%h want %h", bus.b, m_b);
        end
    endtask

    task automatic test_listo_nuevo();
        int cnt, exp;
        int hold = int'(DEB_CYC) + 4;
        int rel  = int'(DEB_CYC) + 5;
        do_reset();
        press(3'b001, 8'h05, hold, rel, cnt); exp = model_load(3'b001, 8'h05);
        press(3'b010, 8'h03, hold, rel, cnt); exp += model_load(3'b010, 8'h03);
        n_tests++;
        if (bus.listo !== 1'b0 || cnt !== exp) begin
            n_fail++;
            $display("FAIL listo_partial: got listo=%b nuevo_pulses=%0d want listo=0 pulses=%0d",
                     bus.listo, cnt, exp);
        end
        press(3'b100, 8'hE2, hold, rel, cnt); exp = model_load(3'b100, 8'hE2);
        n_tests++;
        if (bus.listo !== 1'b1 || cnt !== exp || bus.op !== 6'h22) begin
            n_fail++;
            $display("FAIL listo_full: got listo=%b pulses=%0d op=%h want listo=1 pulses=%0d op=22",
                     bus.listo, cnt, bus.op, exp);
        end
        press(3'b010, 8'h07, hold, rel, cnt); exp = model_load(3'b010, 8'h07);
        n_tests++;
        if (bus.b !== 8'h07 || cnt !== exp || bus.listo !== 1'b1) begin
            n_fail++;
            $display("FAIL nuevo_reload: got b=%h pulses=%0d listo=%b want b=07 pulses=%0d listo=1",
                     bus.b, cnt, bus.listo, exp);
        end
    endtask

    task automatic test_priority();
        int cnt;
        press(3'b101, 8'h11, int'(DEB_CYC) + 4, int'(DEB_CYC) + 5, cnt);
        void'(model_load(3'b101, 8'h11));
        for (int i = 0; i < 20; i++) tick();
        n_tests++;
        if (bus.a !== 8'h11 || bus.op !== m_op) begin
            n_fail++;
            $display("FAIL priority_a_op: got a=%h op=%h want a=11 op=%h", bus.a, bus.op, m_op);
        end
    endtask

    // Random clean presses, optionally preceded by a too-short glitch on a random button
    task automatic test_random();
        int cnt, exp;
        logic [2:0] mask;
        logic [7:0] val;
        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                bus.entrada = 8'($urandom);
                case ($urandom_range(0, 2))
                    0: bus.boton_a  = 1'b1;
                    1: bus.boton_b  = 1'b1;
                    default: bus.boton_op = 1'b1;
                endcase
                for (int g = 0; g < int'($urandom_range(1, DEB_CYC - 1)); g++) tick();
                bus.boton_a  = 1'b0;
                bus.boton_b  = 1'b0;
                bus.boton_op = 1'b0;
                for (int g = 0; g < 4; g++) tick();
            end
            mask = 3'($urandom_range(1, 7));
            val  = 8'($urandom);
            press(mask, val, int'($urandom_range(DEB_CYC, DEB_CYC + 6)),
                  int'($urandom_range(DEB_CYC + 5, DEB_CYC + 8)), cnt);
            exp = model_load(mask, val);
            n_tests++;
            if (bus.a !== m_a || bus.b !== m_b || bus.op !== m_op ||
                bus.listo !== (m_fa & m_fb & m_fop) || bus.sel !== 2'd0 || cnt !== exp) begin
                n_fail++;
                $display("FAIL random it%0d mask=%b: got a=%h b=%h op=%h listo=%b sel=%0d pulses=%0d want a=%h b=%h op=%h listo=%b sel=0 pulses=%0d",
                         it, mask, bus.a, bus.b, bus.op, bus.listo, bus.sel, cnt,
                         m_a, m_b, m_op, m_fa & m_fb & m_fop, exp);
            end
        end
    endtask

    // Reset during debounce aborts the pending load and clears loaded operands at once
    task automatic test_reset_abort();
        int cnt;
        press(3'b001, 8'hC3, int'(DEB_CYC) + 4, int'(DEB_CYC) + 5, cnt);
        void'(model_load(3'b001, 8'hC3));
        bus.entrada = 8'h77;
        bus.boton_b = 1'b1;
        tick();
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.a, bus.b, bus.op, bus.listo, bus.nuevo} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_cycle: got a=%h b=%h op=%h listo=%b nuevo=%b want all 0",
                     bus.a, bus.b, bus.op, bus.listo, bus.nuevo);
        end
        bus.boton_b = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        model_clear();
        for (int i = 0; i < 20; i++) tick();
        n_tests++;
        if (bus.a !== m_a || bus.b !== m_b) begin
            n_fail++;
            $display("FAIL reset_abort_load: got a=%h b=%h want a=%h b=%h", bus.a, bus.b, m_a, m_b);
        end
    endtask

`ifdef CARGADOR_SEQ_EN
    task automatic test_seq();
        int cnt;
        int hold = int'(DEB_CYC) + 4;
        int rel  = int'(DEB_CYC) + 5;
        do_reset();
        n_tests++;
        if (bus.sel !== 2'd0) begin
            n_fail++;
            $display("FAIL seq_reset_sel: got %0d want 0", bus.sel);
        end
        press(3'b001, 8'h01, hold, rel, cnt);
        n_tests++;
        if (bus.a !== 8'h01 || bus.sel !== 2'd1) begin
            n_fail++;
            $display("FAIL seq_press1: got a=%h sel=%0d want a=01 sel=1", bus.a, bus.sel);
        end
        press(3'b001, 8'h02, hold, rel, cnt);
        n_tests++;
        if (bus.b !== 8'h02 || bus.sel !== 2'd2) begin
            n_fail++;
            $display("FAIL seq_press2: got b=%h sel=%0d want b=02 sel=2", bus.b, bus.sel);
        end
        press(3'b001, 8'h03, hold, rel, cnt);
        n_tests++;
        if (bus.op !== 6'h03 || bus.sel !== 2'd0 || bus.listo !== 1'b1) begin
            n_fail++;
            $display("FAIL seq_press3: got op=%h sel=%0d listo=%b want op=03 sel=0 listo=1",
                     bus.op, bus.sel, bus.listo);
        end
        press(3'b001, 8'h44, hold, rel, cnt);
        press(3'b010, 8'h55, hold, rel, cnt);
        n_tests++;
        if (bus.sel !== 2'd0 || bus.a !== 8'h44 || bus.b !== 8'h02) begin
            n_fail++;
            $display("FAIL seq_return: got sel=%0d a=%h b=%h want sel=0 a=44 b=02",
                     bus.sel, bus.a, bus.b);
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef CARGADOR_SEQ_EN
        test_seq();
`else
        test_latency();
        test_glitch();
        test_listo_nuevo();
        test_priority();
        test_random();
        test_reset_abort();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
